// File: rtl/mac_table_scheduler_pkg.sv
// Shared types and constants for the MAC table scheduler.
//   state_t    : scheduler FSM states
//   request_t  : captured request payload (learn flag, MAC, port)
//   is_group_mac() : multicast/broadcast test on the I/G bit
package mac_table_pkg;

    localparam int unsigned CAM_TABLE_DEPTH = 16;
    localparam int unsigned MAC_WIDTH       = 48;
    localparam int unsigned MULTICAST_BIT   = 40;
    localparam int unsigned PORT_WIDTH      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_LOOKUP_ISSUE,
        S_LOOKUP_WAIT,
        S_LOOKUP_COMPARE,
        S_RESPOND
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [MAC_WIDTH-1:0]  mac;
        logic [PORT_WIDTH-1:0] port;
    } request_t;

    // Group (multicast/broadcast) addresses are never learned destinations.
    function automatic logic is_group_mac(input logic [MAC_WIDTH-1:0] mac);
        return mac[MULTICAST_BIT];
    endfunction

endpackage

// File: rtl/mac_table_scheduler_if.sv
// Request/response and CAM-table bus of the MAC table scheduler.
//   slave  : scheduler side (takes requests, drives responses and table ports)
//   master : requester/table side
interface mac_table_scheduler_if #(
    parameter int unsigned NUMBER_OF_REQUESTERS = 2
) ();

    logic [NUMBER_OF_REQUESTERS-1:0]                              request_valid;
    logic [NUMBER_OF_REQUESTERS-1:0]                              request_write;
    logic [NUMBER_OF_REQUESTERS-1:0][mac_table_pkg::MAC_WIDTH-1:0] request_mac;
    logic [NUMBER_OF_REQUESTERS-1:0][mac_table_pkg::PORT_WIDTH-1:0] request_port;
    logic [NUMBER_OF_REQUESTERS-1:0]                              request_ready;
    logic [NUMBER_OF_REQUESTERS-1:0]                              response_valid;
    logic                                                         response_hit;
    logic [mac_table_pkg::PORT_WIDTH-1:0]                         response_port;
    logic [mac_table_pkg::PORT_WIDTH-1:0]                         cam_table_read_address;
    logic [mac_table_pkg::MAC_WIDTH-1:0]                          cam_table_read_data;
    logic [mac_table_pkg::PORT_WIDTH-1:0]                         cam_table_write_address;
    logic [mac_table_pkg::MAC_WIDTH-1:0]                          cam_table_write_data;
    logic                                                         cam_table_write_data_valid;

    modport slave (
        input  request_valid, request_write, request_mac, request_port,
        output request_ready, response_valid, response_hit, response_port,
        output cam_table_read_address,
        input  cam_table_read_data,
        output cam_table_write_address, cam_table_write_data, cam_table_write_data_valid
    );

    modport master (
        output request_valid, request_write, request_mac, request_port,
        input  request_ready, response_valid, response_hit, response_port,
        input  cam_table_read_address,
        output cam_table_read_data,
        input  cam_table_write_address, cam_table_write_data, cam_table_write_data_valid
    );

endinterface

// File: rtl/mac_table_scheduler_round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester after the last one granted.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   request      : request vector
//   update       : grant taken this cycle; advance the pointer to index_c
//   grant_c      : one-hot grant (combinational)
//   index_c      : binary index of grant_c (combinational)
module round_robin_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  request,
    input  logic          update,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] index_c
);

    logic [IW-1:0] last_q, last_d;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        logic          found;
        int unsigned   cand;
        logic [IW-1:0] cand_idx;
        grant_c  = '0;
        index_c  = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand     = (32'(last_q) + i) % N;
            cand_idx = IW'(cand);
            if (!found && request[cand_idx]) begin
                found             = 1'b1;
                grant_c[cand_idx] = 1'b1;
                index_c           = cand_idx;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = index_c;
        end
    end

    // Reset to the last requester so requester 0 wins the first arbitration.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mac_table_scheduler.sv
// Arbitrates learn/lookup requests onto the shared 16-entry MAC CAM table.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : requests/responses and CAM read/write ports (slave side)
//   aging_tick   : aging strobe (only used when MAC_TABLE_AGING_EN is defined)
//   table_busy   : an operation is in progress
// Build option MAC_TABLE_AGING_EN adds per-entry age counters that expire
// entries after AGE_LIMIT ticks; without it valid bits clear only on reset.
module mac_table_scheduler
    import mac_table_pkg::*;
#(
    parameter int unsigned NUMBER_OF_RMII_PORTS = 2,
    parameter int unsigned NUMBER_OF_REQUESTERS = 2,
    parameter int unsigned AGE_LIMIT            = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    mac_table_scheduler_if.slave bus,
    input  logic                 aging_tick,
    output logic                 table_busy
);

    localparam int unsigned R  = NUMBER_OF_REQUESTERS;
    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;
    localparam logic [PORT_WIDTH-1:0] LAST_ENTRY = PORT_WIDTH'(NUMBER_OF_RMII_PORTS - 1);

    state_t                     state_q, state_d;
    request_t                   req_q, req_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [PORT_WIDTH-1:0]      addr_q, addr_d;
    logic                       hit_q, hit_d;
    logic [PORT_WIDTH-1:0]      port_q, port_d;
    logic [PORT_WIDTH-1:0]      wr_addr_q, wr_addr_d;
    logic [MAC_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [R-1:0]               ready_q, ready_d;
    logic [R-1:0]               resp_valid_q, resp_valid_d;
    logic                       busy_q, busy_d;
    logic [CAM_TABLE_DEPTH-1:0] valid_q, valid_d;

    logic [R-1:0]  grant_c;
    logic [IW-1:0] arb_idx_c;
    logic          accept_c;
    logic          learn_c;
    logic          match_c;

    function automatic logic port_in_range(input logic [PORT_WIDTH-1:0] p);
        return 32'(p) < NUMBER_OF_RMII_PORTS;
    endfunction

    round_robin_arbiter #(.N(R)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .request (bus.request_valid),
        .update  (accept_c),
        .grant_c (grant_c),
        .index_c (arb_idx_c)
    );

    assign accept_c = (state_q == S_IDLE) && (|bus.request_valid);
    assign learn_c  = (state_q == S_WRITE) && req_q.write && port_in_range(req_q.port);
    assign match_c  = (bus.cam_table_read_data == req_q.mac) && valid_q[addr_q];

    // Next state and next registered outputs; outputs are computed from the
    // next state so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        hit_d        = hit_q;
        port_d       = port_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_valid_d   = 1'b0;
        ready_d      = '0;
        resp_valid_d = '0;
        busy_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    ready_d    = grant_c;
                    idx_d      = arb_idx_c;
                    req_d.write = bus.request_write[arb_idx_c];
                    req_d.mac   = bus.request_mac[arb_idx_c];
                    req_d.port  = bus.request_port[arb_idx_c];
                    if (req_d.write) begin
                        state_d = S_WRITE;
                        if (port_in_range(req_d.port)) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = req_d.port;
                            wr_data_d  = req_d.mac;
                        end
                    end else if (is_group_mac(req_d.mac)) begin
                        state_d = S_RESPOND;
                        hit_d   = 1'b0;
                        port_d  = '0;
                    end else begin
                        state_d = S_LOOKUP_ISSUE;
                        addr_d  = '0;
                    end
                end
            end
            S_WRITE: begin
                hit_d   = learn_c;
                port_d  = learn_c ? req_q.port : '0;
                state_d = S_RESPOND;
            end
            S_LOOKUP_ISSUE: begin
                state_d = S_LOOKUP_WAIT;
            end
            S_LOOKUP_WAIT: begin
                state_d = S_LOOKUP_COMPARE;
            end
            S_LOOKUP_COMPARE: begin
                if (match_c) begin
                    hit_d   = 1'b1;
                    port_d  = addr_q;
                    state_d = S_RESPOND;
                end else if (addr_q == LAST_ENTRY) begin
                    hit_d   = 1'b0;
                    port_d  = '0;
                    state_d = S_RESPOND;
                end else begin
                    addr_d  = addr_q + PORT_WIDTH'(1);
                    state_d = S_LOOKUP_ISSUE;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        if (state_d == S_RESPOND) begin
            resp_valid_d[idx_d] = 1'b1;
        end
    end

`ifdef MAC_TABLE_AGING_EN
    localparam int unsigned AW = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

    logic [CAM_TABLE_DEPTH-1:0][AW-1:0] age_q, age_d;

    // Tick ages every live entry; a learn in the same cycle overrides its entry.
    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (aging_tick) begin
            for (int e = 0; e < CAM_TABLE_DEPTH; e++) begin
                if (valid_q[e]) begin
                    age_d[e] = age_q[e] + AW'(1);
                    if (age_d[e] == AW'(AGE_LIMIT)) begin
                        valid_d[e] = 1'b0;
                    end
                end
            end
        end
        if (learn_c) begin
            valid_d[req_q.port] = 1'b1;
            age_d[req_q.port]   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic unused_aging_c;
    assign unused_aging_c = aging_tick ^ (AGE_LIMIT != 0);

    always_comb begin
        valid_d = valid_q;
        if (learn_c) begin
            valid_d[req_q.port] = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_q        <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            port_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            ready_q      <= '0;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            hit_q        <= hit_d;
            port_q       <= port_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_valid_q   <= wr_valid_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
        end
    end

    assign bus.request_ready              = ready_q;
    assign bus.response_valid             = resp_valid_q;
    assign bus.response_hit               = hit_q;
    assign bus.response_port              = port_q;
    assign bus.cam_table_read_address     = addr_q;
    assign bus.cam_table_write_address    = wr_addr_q;
    assign bus.cam_table_write_data       = wr_data_q;
    assign bus.cam_table_write_data_valid = wr_valid_q;
    assign table_busy                     = busy_q;

endmodule

// File: tb/tb_mac_table_scheduler.sv
// Bench for mac_table_scheduler: CAM table model with 2-cycle read latency,
// directed scenarios plus random learn/lookup traffic against a table model.
module tb_mac_table_scheduler;

    localparam int unsigned P   = 2;
    localparam int unsigned R   = 2;
    localparam int unsigned AL  = 2;
    localparam int          TMO = 80;

    localparam logic [47:0] MAC_AA = 48'h0200_0000_00AA;
    localparam logic [47:0] MAC_BB = 48'h0200_0000_00BB;
    localparam logic [47:0] MAC_CC = 48'h0200_0000_00CC;
    localparam logic [47:0] MAC_DD = 48'h0200_0000_00DD;
    localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_MC = 48'h0100_5E00_0001;

    logic clk = 1'b0;
    logic rst;
    logic aging_tick;
    logic table_busy;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    mac_table_scheduler_if #(.NUMBER_OF_REQUESTERS(R)) bus ();

    mac_table_scheduler #(
        .NUMBER_OF_RMII_PORTS (P),
        .NUMBER_OF_REQUESTERS (R),
        .AGE_LIMIT            (AL)
    ) dut (
        .clock      (clk),
        .reset      (rst),
        .bus        (bus),
        .aging_tick (aging_tick),
        .table_busy (table_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // CAM table: write port, and read data two cycles after the address
    logic [47:0] cam_mem [16];
    logic [47:0] rd_p1, rd_p2;
    logic        preload_en;
    logic [47:0] preload_mac;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 16; i++) cam_mem[i] <= preload_mac;
        end else if (bus.cam_table_write_data_valid) begin
            cam_mem[bus.cam_table_write_address] <= bus.cam_table_write_data;
        end
        rd_p1 <= cam_mem[bus.cam_table_read_address];
        rd_p2 <= rd_p1;
    end
    assign bus.cam_table_read_data = rd_p2;

    // Reference model: learned MAC per port, liveness, age, last grant
    logic [47:0] m_mac   [16];
    bit          m_valid [16];
    int          m_age   [16];
    int          m_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_age[i]   = 0;
            m_mac[i]   = '0;
        end
        m_last = R - 1;
    endtask

    task automatic model_tick();
`ifdef MAC_TABLE_AGING_EN
        for (int i = 0; i < 16; i++) begin
            if (m_valid[i]) begin
                m_age[i]++;
                if (m_age[i] == AL) m_valid[i] = 0;
            end
        end
`endif
    endtask

    task automatic model_lookup(input logic [47:0] mac, output bit hit, output int port, output int lat);
        hit  = 0;
        port = 0;
        lat  = 3 * P + 1;
        if (mac[40]) begin
            lat = 1;
        end else begin
            for (int e = P - 1; e >= 0; e--) begin
                if (m_valid[e] && m_mac[e] == mac) begin
                    hit  = 1;
                    port = e;
                    lat  = 3 * e + 4;
                end
            end
        end
    endtask

    task automatic model_learn(input logic [47:0] mac, input int port, input bit tick,
                               output bit hit, output int lat);
        if (tick) model_tick();
        hit = (port < P);
        lat = 2;
        if (hit) begin
            m_mac[port]   = mac;
            m_valid[port] = 1;
            m_age[port]   = 0;
        end
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        aging_tick = 1'b1;
        @(negedge clk);
        aging_tick = 1'b0;
        model_tick();
    endtask

    // One complete transaction from requester r, checked against the model.
    task automatic run_req(input int r, input bit w, input logic [47:0] mac,
                           input logic [3:0] port, input bit tick_on_write);
        bit          exp_hit;
        int          exp_port;
        int          exp_lat;
        bit          exp_wr;
        int          n;
        int          lat;
        int          wr_cnt;
        bit          seen;
        bit          addr_moved;
        logic [3:0]  addr0;

        exp_port = 0;
        exp_wr   = w && (int'(port) < P);
        if (w) begin
            model_learn(mac, int'(port), tick_on_write, exp_hit, exp_lat);
            if (exp_hit) exp_port = int'(port);
        end else begin
            model_lookup(mac, exp_hit, exp_port, exp_lat);
        end

        @(negedge clk);
        check("idle_before_req", 64'(table_busy), 64'd0);
        addr0 = bus.cam_table_read_address;
        bus.request_valid[r] = 1'b1;
        bus.request_write[r] = w;
        bus.request_mac[r]   = mac;
        bus.request_port[r]  = port;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.request_ready[r] !== 1'b1 && n < TMO);
        check("ready_pulse", 64'(bus.request_ready), 64'(1) << r);
        bus.request_valid[r] = 1'b0;
        m_last = r;

        check("write_strobe_c1", 64'(bus.cam_table_write_data_valid), 64'(exp_wr));
        if (exp_wr) begin
            check("write_addr", 64'(bus.cam_table_write_address), 64'(port));
            check("write_data", 64'(bus.cam_table_write_data), 64'(mac));
        end
        if (tick_on_write) aging_tick = 1'b1;

        wr_cnt     = 0;
        seen       = 0;
        addr_moved = 0;
        for (lat = 1; lat <= TMO; lat++) begin
            if (lat > 1) @(negedge clk);
            if (lat == 2) aging_tick = 1'b0;
            if (bus.cam_table_write_data_valid === 1'b1) wr_cnt++;
            if (bus.cam_table_read_address !== addr0) addr_moved = 1;
            if (|bus.response_valid) begin
                seen = 1;
                break;
            end
        end
        aging_tick = 1'b0;

        check("response_seen", 64'(seen), 64'd1);
        check("response_latency", 64'(lat), 64'(exp_lat));
        check("response_target", 64'(bus.response_valid), 64'(1) << r);
        check("response_hit", 64'(bus.response_hit), 64'(exp_hit));
        if (!w || exp_hit) check("response_port", 64'(bus.response_port), 64'(exp_port));
        check("write_count", 64'(wr_cnt), 64'(exp_wr));
        if (!w && mac[40]) check("group_no_scan", 64'(addr_moved), 64'd0);
    endtask

    function automatic logic [47:0] pick_mac(input int k);
        logic [47:0] m;
        case (k)
            0:       m = MAC_AA;
            1:       m = MAC_BB;
            2:       m = MAC_CC;
            3:       m = MAC_DD;
            4:       m = MAC_BC;
            default: m = MAC_MC;
        endcase
        return m;
    endfunction

    initial begin
        int n;
        int exp_g;
        int prev;
        int resp_cnt;
        int wr_cnt;
        int rr;
        bit ww;
        int kk;
        int pp;
        bit tt;

        rst               = 1'b1;
        aging_tick        = 1'b0;
        preload_en        = 1'b1;
        preload_mac       = MAC_BB;
        bus.request_valid = '0;
        bus.request_write = '0;
        bus.request_mac   = '0;
        bus.request_port  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus.request_ready), 64'd0);
        check("rst_resp_valid", 64'(bus.response_valid), 64'd0);
        check("rst_hit", 64'(bus.response_hit), 64'd0);
        check("rst_port", 64'(bus.response_port), 64'd0);
        check("rst_rd_addr", 64'(bus.cam_table_read_address), 64'd0);
        check("rst_wr_addr", 64'(bus.cam_table_write_address), 64'd0);
        check("rst_wr_data", 64'(bus.cam_table_write_data), 64'd0);
        check("rst_wr_valid", 64'(bus.cam_table_write_data_valid), 64'd0);
        check("rst_busy", 64'(table_busy), 64'd0);
        preload_en = 1'b0;
        rst        = 1'b0;

        // Broadcast lookup: immediate miss, no scan
        run_req(0, 1'b0, MAC_BC, 4'd0, 1'b0);
        // Empty table misses even though every CAM word holds the MAC
        run_req(1, 1'b0, MAC_BB, 4'd0, 1'b0);
        // Learn then lookup from the other requester
        run_req(0, 1'b1, MAC_AA, 4'd1, 1'b0);
        run_req(1, 1'b0, MAC_AA, 4'd0, 1'b0);
        // Out-of-range learn port
        run_req(0, 1'b1, MAC_CC, 4'd5, 1'b0);

        // Both requesters hold learns: alternating grants 3 cycles apart
        @(negedge clk);
        bus.request_write  = '1;
        bus.request_mac[0] = MAC_AA;
        bus.request_port[0] = 4'd0;
        bus.request_mac[1] = MAC_BB;
        bus.request_port[1] = 4'd1;
        bus.request_valid  = '1;
        exp_g = (m_last + 1) % R;
        prev  = 0;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.request_ready === '0 && n < TMO);
            check("grant_order", 64'(bus.request_ready), 64'(1) << exp_g);
            if (g > 0) check("grant_gap", 64'(cyc - prev), 64'd3);
            prev   = cyc;
            m_last = exp_g;
            exp_g  = (exp_g + 1) % R;
            if (g == 3) bus.request_valid = '0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (table_busy && n < TMO);
        check("contention_drain", 64'(table_busy), 64'd0);
        m_mac[0] = MAC_AA; m_valid[0] = 1; m_age[0] = 0;
        m_mac[1] = MAC_BB; m_valid[1] = 1; m_age[1] = 0;

        // Aging: two ticks expire an entry; a learn on the second tick keeps it
        run_req(0, 1'b1, MAC_CC, 4'd0, 1'b0);
        tick_pulse();
        tick_pulse();
        run_req(1, 1'b0, MAC_CC, 4'd0, 1'b0);
        run_req(0, 1'b1, MAC_CC, 4'd0, 1'b0);
        tick_pulse();
        run_req(0, 1'b1, MAC_CC, 4'd0, 1'b1);
        run_req(1, 1'b0, MAC_CC, 4'd0, 1'b0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            rr = int'($urandom_range(0, R - 1));
            ww = 1'($urandom_range(0, 1));
            kk = int'($urandom_range(0, 5));
            pp = int'($urandom_range(0, 5));
            tt = ww && ($urandom_range(0, 4) == 0);
            run_req(rr, ww, pick_mac(kk), 4'(pp), tt);
            if ($urandom_range(0, 3) == 0) tick_pulse();
        end

        // Reset in the middle of a lookup: no response, no write, table cleared
        run_req(0, 1'b1, MAC_AA, 4'd0, 1'b0);
        @(negedge clk);
        bus.request_write[0] = 1'b0;
        bus.request_mac[0]   = MAC_DD;
        bus.request_valid[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.request_ready[0] !== 1'b1 && n < TMO);
        bus.request_valid[0] = 1'b0;
        resp_cnt = 0;
        wr_cnt   = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (|bus.response_valid) resp_cnt++;
            if (bus.cam_table_write_data_valid === 1'b1) wr_cnt++;
            if (k == 0) rst = 1'b1;
            if (k == 2) rst = 1'b0;
        end
        check("abort_no_response", 64'(resp_cnt), 64'd0);
        check("abort_no_write", 64'(wr_cnt), 64'd0);
        check("abort_idle", 64'(table_busy), 64'd0);
        model_reset();
        run_req(1, 1'b0, MAC_AA, 4'd0, 1'b0);

        // Arbiter pointer after reset favours requester 0
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.request_write = '0;
        bus.request_mac[0] = MAC_BC;
        bus.request_mac[1] = MAC_BC;
        bus.request_valid  = '1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.request_ready === '0 && n < TMO);
        check("first_grant_after_reset", 64'(bus.request_ready), 64'd1);
        bus.request_valid = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_table_scheduler.md
# mac_table_scheduler

Shares the single 16-entry MAC CAM table between several switch-core requesters, each of which issues learn (write source MAC against a port) or lookup (find the egress port for a destination MAC) requests. Grants one request at a time round-robin, sequences the table's 2-cycle read pipeline for the port scan, and returns a per-requester response. Sits between the data orchestrators and the CAM table, replacing their direct table access.

## Interface
- NUMBER_OF_RMII_PORTS, 2, table entries scanned (entry index = port); legal 1..16
- NUMBER_OF_REQUESTERS, 2, number of request channels; legal 1..8
- AGE_LIMIT, 15, aging ticks before an entry expires (used only with aging compiled in)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- request_valid  in  [R]  request pending per requester, held until request_ready
- request_write  in  [R]  1 = learn, 0 = lookup
- request_mac  in  [R][47:0]  MAC to learn or look up
- request_port  in  [R][3:0]  port for learn; ignored for lookup
- request_ready  out  [R]  one-cycle accept pulse
- response_valid  out  [R]  one-cycle response pulse to the accepted requester
- response_hit  out  1  lookup found / learn written
- response_port  out  4  matched port (lookup) or written port (learn)
- cam_table_read_address  out  4  table read address; data returns 2 cycles later
- cam_table_read_data  in  48  table read data
- cam_table_write_address, cam_table_write_data, cam_table_write_data_valid  out  4 / 48 / 1  table write port
- aging_tick  in  1  one-cycle aging strobe
- table_busy  out  1  high whenever state != S_IDLE

## Operation
- States: S_IDLE, S_WRITE, S_LOOKUP_ISSUE, S_LOOKUP_WAIT, S_LOOKUP_COMPARE, S_RESPOND.
- S_IDLE: round-robin grant among request_valid, starting from last-granted+1 (reset: requester 0 first). Capture mac, port, write, index. Learn -> S_WRITE; lookup with request_mac[40] = 1 (multicast/broadcast) -> S_RESPOND, miss, no scan; other lookup -> S_LOOKUP_ISSUE, read address 0.
- S_WRITE: if port < NUMBER_OF_RMII_PORTS, write_data_valid = 1 for this cycle only, address = port, data = mac, valid[port] set, hit = 1; otherwise no write, hit = 0. -> S_RESPOND.
- Lookup: ISSUE presents the address; WAIT; COMPARE checks read_data == mac && valid[address]. Hit -> S_RESPOND, port = address. Miss -> address+1 to ISSUE, or, past the last entry, -> S_RESPOND with hit = 0, port = 0.
- S_RESPOND: response_valid[index] = 1 for one cycle -> S_IDLE.
- Per-entry valid bits are cleared by reset, so an empty table always misses regardless of CAM contents.

## Timing
- Reset values: request_ready 0, response_valid 0, response_hit 0, response_port 0, read address 0, write address/data 0, write_data_valid 0, table_busy 0, valid bits all 0, arbiter pointer to last requester.
- Edge E0 accepts; request_ready pulses in cycle 1. The requester may change or drop its request from the edge after that cycle.
- Learn: write in cycle 1, response in cycle 2, next accept at the end of cycle 3.
- Lookup hit on entry e: response in cycle 3e+4. Full miss: response in cycle 3P+1. Multicast: response in cycle 1.
- Only one response is ever outstanding. Requesters not granted keep request_valid high and must wait.
- A reset during any operation aborts it with no response pulse and no write.

## Configuration
- MAC_TABLE_AGING_EN defined: per-entry age counter, $clog2(AGE_LIMIT+1) bits. On aging_tick each valid entry's counter increments; when it reaches AGE_LIMIT, that entry's valid bit clears. A learn clears the counter to 0. A learn and a tick on the same entry in the same cycle: the learn wins (age 0, valid 1).
- Undefined: no counters. aging_tick is ignored, and valid bits clear only on reset.

## Structure
- mac_table_pkg: state enum, CAM_TABLE_DEPTH = 16, MAC_WIDTH = 48, MULTICAST_BIT = 40.
- Sub-module round_robin_arbiter (request vector, update strobe -> one-hot grant, index), reusable elsewhere in the switch core.

## Test plan
- Requester 0 learns 02:00:00:00:00:AA on port 1. Requester 1 then looks up the same MAC -> write in cycle 1; lookup response in cycle 7, hit = 1, port = 1.
- Lookup of 02:00:00:00:00:BB on an empty table, P = 2 -> response in cycle 7, hit = 0, port = 0. No write strobe.
- Lookup of FF:FF:FF:FF:FF:FF -> response in cycle 1, hit = 0, read address never leaves 0.
- Both requesters hold learns continuously -> grants alternate 0, 1, 0, 1, each 3 cycles apart.
- Learn with port = 5 and P = 2 -> no cam_table_write_data_valid; response hit = 0.
- With MAC_TABLE_AGING_EN and AGE_LIMIT = 2: learn, then two aging_ticks, then lookup -> miss. Repeat with a learn coincident with the second tick -> hit.
